// File: rtl/arith_pipe_if.sv
// arith_pipe_if: instruction, writeback and debug-read signals of arith_pipe.
interface arith_pipe_if #(parameter int WIDTH = 32);
    logic             inst_valid;
    logic [31:0]      inst;
    logic             inst_ready;
    logic             wb_valid;
    logic [4:0]       wb_addr;
    logic [WIDTH-1:0] wb_data;
    logic             except;
    logic [4:0]       dbg_addr;
    logic [WIDTH-1:0] dbg_data;
    modport master (output inst_valid, inst, dbg_addr,
                    input inst_ready, wb_valid, wb_addr, wb_data, except, dbg_data);
    modport slave  (input inst_valid, inst, dbg_addr,
                    output inst_ready, wb_valid, wb_addr, wb_data, except, dbg_data);
endinterface

// File: rtl/arith_pipe.sv
// arith_pipe: 2-stage MIPS-subset ALU pipeline with a 32-entry register file,
// E-stage bypass and a sticky exception that halts on bad opcodes or trapped overflow.
module arith_pipe #(
    parameter int WIDTH       = 32,
    parameter bit TRAP_ON_OVF = 1'b0
) (
    input logic        clock,
    input logic        reset,
    arith_pipe_if.slave bus
);
    typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR} alu_t;

    logic [WIDTH-1:0] regs [32];
    logic             e_valid, e_bad, e_arith, e_ovf, e_fault, e_wr, accept;
    alu_t             e_alu, d_alu;
    logic [4:0]       e_dst, d_dst, rs, rt, rd;
    logic [WIDTH-1:0] e_a, e_b, e_res, rs_val, rt_val, d_a, d_b;
    logic [5:0]       opc, fn;
    logic [15:0]      imm;
    logic             d_bad, d_arith;

    assign opc = bus.inst[31:26];
    assign rs  = bus.inst[25:21];
    assign rt  = bus.inst[20:16];
    assign rd  = bus.inst[15:11];
    assign fn  = bus.inst[5:0];
    assign imm = bus.inst[15:0];

    always_comb begin
        e_res = e_alu == ALU_ADD ? e_a + e_b :
                e_alu == ALU_SUB ? e_a - e_b :
                e_alu == ALU_AND ? e_a & e_b :
                e_alu == ALU_OR  ? e_a | e_b :
                e_alu == ALU_XOR ? e_a ^ e_b : ~(e_a | e_b);
        // Signed overflow: operands agree in sign (add) or differ (sub) and the result flips
        e_ovf = e_arith &&
                ((e_alu == ALU_SUB) ? (e_a[WIDTH-1] != e_b[WIDTH-1]) : (e_a[WIDTH-1] == e_b[WIDTH-1])) &&
                (e_res[WIDTH-1] != e_a[WIDTH-1]);
        e_fault = e_valid && (e_bad || (TRAP_ON_OVF && e_ovf));
        e_wr = e_valid && !e_fault;
        bus.inst_ready = !reset && !bus.except && !e_fault;
        accept = bus.inst_valid && bus.inst_ready;
        rs_val = rs == 5'd0 ? '0 : (e_wr && e_dst == rs) ? e_res : regs[rs];
        rt_val = rt == 5'd0 ? '0 : (e_wr && e_dst == rt) ? e_res : regs[rt];
        bus.dbg_data = bus.dbg_addr == 5'd0 ? '0 : regs[bus.dbg_addr];
    end

    always_comb begin
        d_bad   = 1'b0;
        d_arith = 1'b0;
        d_alu   = ALU_OR;
        d_dst   = rt;
        d_a     = rs_val;
        d_b     = WIDTH'(imm);
        case (opc)
            6'h00: begin
                d_dst = rd;
                d_b   = rt_val;
                case (fn)
                    6'h20: begin d_alu = ALU_ADD; d_arith = 1'b1; end
                    6'h22: begin d_alu = ALU_SUB; d_arith = 1'b1; end
                    6'h24: d_alu = ALU_AND;
                    6'h25: d_alu = ALU_OR;
                    6'h26: d_alu = ALU_XOR;
                    6'h27: d_alu = ALU_NOR;
                    default: d_bad = 1'b1;
                endcase
            end
            6'h08: begin d_alu = ALU_ADD; d_arith = 1'b1; d_b = WIDTH'($signed(imm)); end
            6'h0C: d_alu = ALU_AND;
            6'h0D: d_alu = ALU_OR;
            6'h0E: d_alu = ALU_XOR;
            6'h0F: begin d_a = '0; d_b = WIDTH'($signed({imm, 16'h0000})); end
            default: d_bad = 1'b1;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
            e_valid      <= 1'b0;
            e_bad        <= 1'b0;
            e_arith      <= 1'b0;
            e_alu        <= ALU_ADD;
            e_dst        <= '0;
            e_a          <= '0;
            e_b          <= '0;
            bus.wb_valid <= 1'b0;
            bus.wb_addr  <= '0;
            bus.wb_data  <= '0;
            bus.except   <= 1'b0;
        end else begin
            bus.wb_valid <= e_wr;
            if (e_wr) begin
                bus.wb_addr <= e_dst;
                bus.wb_data <= e_res;
                if (e_dst != 5'd0) regs[e_dst] <= e_res;
            end
            if (e_fault) bus.except <= 1'b1;
            e_valid <= accept;
            if (accept) begin
                e_bad   <= d_bad;
                e_arith <= d_arith;
                e_alu   <= d_alu;
                e_dst   <= d_dst;
                e_a     <= d_a;
                e_b     <= d_b;
            end
        end
    end
endmodule

// File: doc/arith_pipe.md
ARITH_PIPE -- requirements
Module: arith_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath and register width; legal values are WIDTH >= 32.
REQ-002 SHALL have parameter TRAP_ON_OVF, default 0; when 1, signed overflow on add/sub/addi raises an exception.
REQ-003 SHALL have one clock; reset is asynchronous and active-high; the ports are named clock and reset.
REQ-004 Port list:
- clock  input  1  rising-edge clock.
- reset  input  1  async active-high reset.
- inst_valid  input  1  inst holds an instruction.
- inst  input  32  MIPS-format instruction.
- inst_ready  output  1  block can accept inst this cycle.
- wb_valid  output  1  a register write retired last edge.
- wb_addr  output  5  retired destination register.
- wb_data  output  WIDTH  retired value.
- except  output  1  sticky exception/halt flag.
- dbg_addr  input  5  debug register index.
- dbg_data  output  WIDTH  combinational read of register dbg_addr.

Function
REQ-005 SHALL contain 32 registers of WIDTH bits; register 0 SHALL read 0 and SHALL ignore writes; dbg_data SHALL return the post-write contents.
REQ-006 SHALL accept an instruction on a rising edge where inst_valid and inst_ready are both high.
REQ-007 SHALL be a 2-stage pipeline:
- Accept: decode, then read rs/rt into the E register.
- E: execute, then write the regfile on the next edge.
- Throughput is 1 instruction per cycle.
REQ-008 R-type instructions (opcode 0x00) SHALL write rd = rs op rt. Supported funct codes: 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x26 xor, 0x27 nor. Arithmetic is modulo 2^WIDTH.
REQ-009 I-type instructions SHALL write rt:
- 0x08 addi: rs + sign-extended imm16.
- 0x0C andi, 0x0D ori, 0x0E xori: rs op zero-extended imm16.
- 0x0F lui: {imm16, 16'b0}, sign-extended to WIDTH.
REQ-010 Any other opcode/funct combination SHALL be an unrecognised instruction.
REQ-011 Latency: for an instruction accepted at edge N, the register write, wb_valid=1, wb_addr and wb_data SHALL all take effect at edge N+1 and hold for one cycle.
REQ-012 If no instruction retires at an edge, wb_valid SHALL be 0 for the following cycle; wb_addr and wb_data are don't-care while wb_valid=0.
REQ-013 A write to register 0 SHALL still retire with wb_valid=1, wb_addr=0, wb_data equal to the computed value, but the register SHALL stay 0.
REQ-014 Bypass: when an operand index of the accepting instruction equals the nonzero destination of the instruction in E, the accepting instruction SHALL use E's result, not the stale regfile value.
REQ-015 When E holds an unrecognised instruction, or a trapping overflow (TRAP_ON_OVF=1), then:
- No register write and wb_valid=0 at the next edge.
- except is set at that edge.
- inst_ready is 0 in the same cycle E holds the faulting instruction, so no younger instruction is accepted.
REQ-016 After except is set, it SHALL remain 1 and inst_ready SHALL remain 0 until reset; no further writes SHALL occur.
REQ-017 With TRAP_ON_OVF=0, overflow SHALL wrap silently and retire normally.
REQ-018 inst_ready SHALL be 1 whenever except=0 and E holds no faulting instruction; inst is ignored when inst_valid=0 (bubble in E).

Reset
REQ-019 Reset SHALL asynchronously clear:
- all 32 registers to 0;
- the E stage to empty;
- wb_valid, wb_addr, wb_data to 0;
- except to 0.
REQ-020 While reset=1, inst_ready SHALL be 0; assertion mid-operation SHALL discard the in-flight instruction without a write.
REQ-021 The first acceptance SHALL be possible on the first rising edge after reset deasserts.

Verification
REQ-022 ori $1,$0,0x1234 then addi $2,$1,-4 back-to-back -> wb $1=0x1234, then wb $2=0x1230 via bypass, 1 retire per cycle.
REQ-023 lui $3,0x8000 with WIDTH=64 -> $3=0xFFFFFFFF80000000; then nor $4,$0,$0 -> $4 = all ones.
REQ-024 TRAP_ON_OVF=1: lui $5,0x7FFF; ori $5,$5,0xFFFF; addi $6,$5,1 -> no write of $6, except=1, inst_ready=0 from the cycle addi is in E; $6 remains 0.
REQ-025 TRAP_ON_OVF=0 with the same sequence -> $6=0x80000000, except=0.
REQ-026 Unrecognised opcode 0x3F followed by valid add -> except=1 at next edge, add never accepted or retired; reset -> except=0, all registers 0.
REQ-027 addi $0,$0,5 -> wb_valid=1, wb_addr=0, wb_data=5, dbg_data for $0 = 0; reset asserted mid-stream -> in-flight write dropped.
